// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory request/response channel plus the decode-side queue head.
// The master modport is the fetch unit; the slave modport is memory plus decode.
interface instr_fetch_unit_if #(
  parameter int AW = 32
) ();
  logic          imem_req_valid;
  logic [AW-1:0] imem_req_addr;
  logic          imem_req_ready;
  logic          imem_rsp_valid;
  logic [31:0]   imem_rsp_data;
  logic          if_valid;
  logic [AW-1:0] if_pc;
  logic [31:0]   if_instr;
  logic          id_ready;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output if_valid, if_pc, if_instr,
    input  id_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  if_valid, if_pc, if_instr,
    output id_ready
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: one outstanding imem read at a time, {pc, instr} pairs queued for decode.
// Optional misaligned-PC trap enabled by defining FETCH_ALIGN_CHECK_EN.
module instr_fetch_unit #(
  parameter int            DEPTH   = 2,
  parameter int            AW      = 32,
  parameter logic [AW-1:0] IDLE_PC = {AW{1'b1}}
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [AW-1:0]       pc,
  input  logic                flush,
  instr_fetch_unit_if.master  bus,
  output logic                pc_advance,
  output logic                fetch_fault
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_REQ       = 2'd1,
    S_WAIT      = 2'd2,
    S_WAIT_DROP = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic          req_valid_q, req_valid_d;
  logic [AW-1:0] req_addr_q, req_addr_d;
  logic [AW-1:0] cap_pc_q, cap_pc_d;
  logic          pc_advance_q, pc_advance_d;
  logic          drop_pending_q, drop_pending_d;
  logic          fault_q, fault_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          if_valid_q, if_valid_d;
  logic [AW-1:0] mem_pc_q [DEPTH];
  logic [AW-1:0] mem_pc_d [DEPTH];
  logic [31:0]   mem_instr_q [DEPTH];
  logic [31:0]   mem_instr_d [DEPTH];

  logic          misalign_s;
  logic          handshake_s;
  logic          can_issue_s;
  logic          push_s;
  logic          pop_s;
  logic          push_ok_s;

`ifdef FETCH_ALIGN_CHECK_EN
  assign misalign_s = (pc != IDLE_PC) && (pc[1:0] != 2'b00);
`else
  assign misalign_s = 1'b0;
`endif

  // While pc_advance_q is high the PC register is updating, so the pc seen in IDLE is stale.
  assign can_issue_s = (pc != IDLE_PC) && !fault_q && !misalign_s && !pc_advance_q &&
                       (count_q < CW'(DEPTH));
  assign handshake_s = req_valid_q && bus.imem_req_ready;

  // Fetch FSM: next state, request channel and response acceptance.
  always_comb begin
    state_d        = state_q;
    req_valid_d    = req_valid_q;
    req_addr_d     = req_addr_q;
    cap_pc_d       = cap_pc_q;
    drop_pending_d = drop_pending_q;
    pc_advance_d   = 1'b0;
    push_s         = 1'b0;
    if (flush) begin
      req_valid_d = 1'b0;
      case (state_q)
        S_REQ: begin
          if (handshake_s) begin
            state_d        = S_WAIT_DROP;
            drop_pending_d = 1'b1;
          end else begin
            state_d        = S_IDLE;
            drop_pending_d = 1'b0;
          end
        end
        S_WAIT, S_WAIT_DROP: begin
          // A response arriving with the flush is itself the one being discarded.
          if (bus.imem_rsp_valid) begin
            state_d        = S_IDLE;
            drop_pending_d = 1'b0;
          end else begin
            state_d        = S_WAIT_DROP;
            drop_pending_d = 1'b1;
          end
        end
        default: begin
          state_d        = S_IDLE;
          drop_pending_d = 1'b0;
        end
      endcase
    end else begin
      case (state_q)
        S_IDLE: begin
          if (can_issue_s) begin
            state_d     = S_REQ;
            req_valid_d = 1'b1;
            req_addr_d  = {pc[AW-1:2], 2'b00};
            cap_pc_d    = pc;
          end else begin
            state_d     = S_IDLE;
          end
        end
        S_REQ: begin
          if (handshake_s) begin
            state_d     = S_WAIT;
            req_valid_d = 1'b0;
          end else begin
            state_d     = S_REQ;
          end
        end
        S_WAIT: begin
          if (bus.imem_rsp_valid) begin
            state_d      = S_IDLE;
            push_s       = 1'b1;
            pc_advance_d = 1'b1;
          end else begin
            state_d      = S_WAIT;
          end
        end
        S_WAIT_DROP: begin
          if (bus.imem_rsp_valid) begin
            state_d        = S_IDLE;
            drop_pending_d = 1'b0;
          end else begin
            state_d        = S_WAIT_DROP;
          end
        end
        default: begin
          state_d        = S_IDLE;
          req_valid_d    = 1'b0;
          drop_pending_d = 1'b0;
        end
      endcase
    end
  end

  // Alignment fault: latched from IDLE, cleared only by flush.
  always_comb begin
    if (flush) begin
      fault_d = 1'b0;
    end else if ((state_q == S_IDLE) && misalign_s) begin
      fault_d = 1'b1;
    end else begin
      fault_d = fault_q;
    end
  end

  assign pop_s = (count_q != {CW{1'b0}}) && bus.id_ready;

  // Response FIFO: a pop frees its slot before a same-cycle push lands.
  always_comb begin
    count_d     = count_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    mem_pc_d    = mem_pc_q;
    mem_instr_d = mem_instr_q;
    push_ok_s   = 1'b0;
    if (flush) begin
      count_d  = {CW{1'b0}};
      wr_ptr_d = {PW{1'b0}};
      rd_ptr_d = {PW{1'b0}};
    end else begin
      push_ok_s = push_s && ((count_q < CW'(DEPTH)) || pop_s);
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      if (push_ok_s) begin
        mem_pc_d[wr_ptr_q]    = cap_pc_q;
        mem_instr_d[wr_ptr_q] = bus.imem_rsp_data;
        wr_ptr_d              = wr_ptr_q + PW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      count_d = count_q + CW'(push_ok_s) - CW'(pop_s);
    end
    if_valid_d = (count_d != {CW{1'b0}});
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      req_valid_q    <= 1'b0;
      req_addr_q     <= {AW{1'b0}};
      cap_pc_q       <= {AW{1'b0}};
      pc_advance_q   <= 1'b0;
      drop_pending_q <= 1'b0;
      fault_q        <= 1'b0;
      count_q        <= {CW{1'b0}};
      wr_ptr_q       <= {PW{1'b0}};
      rd_ptr_q       <= {PW{1'b0}};
      if_valid_q     <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_pc_q[i]    <= {AW{1'b0}};
        mem_instr_q[i] <= 32'h0000_0000;
      end
    end else begin
      state_q        <= state_d;
      req_valid_q    <= req_valid_d;
      req_addr_q     <= req_addr_d;
      cap_pc_q       <= cap_pc_d;
      pc_advance_q   <= pc_advance_d;
      drop_pending_q <= drop_pending_d;
      fault_q        <= fault_d;
      count_q        <= count_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      if_valid_q     <= if_valid_d;
      mem_pc_q       <= mem_pc_d;
      mem_instr_q    <= mem_instr_d;
    end
  end

  assign bus.imem_req_valid = req_valid_q;
  assign bus.imem_req_addr  = req_addr_q;
  assign bus.if_valid       = if_valid_q;
  assign bus.if_pc          = mem_pc_q[rd_ptr_q];
  assign bus.if_instr       = mem_instr_q[rd_ptr_q];
  assign pc_advance         = pc_advance_q && !flush;
  assign fetch_fault        = fault_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios then random traffic against a queue-based model.
// Builds with or without FETCH_ALIGN_CHECK_EN.
module tb_instr_fetch_unit;
  localparam int          AW      = 32;
  localparam int          DEPTH   = 2;
  localparam logic [31:0] IDLE_PC = 32'hFFFF_FFFF;
`ifdef FETCH_ALIGN_CHECK_EN
  localparam bit ALIGN_CHK = 1'b1;
`else
  localparam bit ALIGN_CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [31:0] pc;
  logic        pc_advance;
  logic        fetch_fault;

  instr_fetch_unit_if #(.AW(AW)) bus ();

  instr_fetch_unit #(.DEPTH(DEPTH), .AW(AW), .IDLE_PC(IDLE_PC)) dut (
    .clk(clk), .rst(rst), .pc(pc), .flush(flush), .bus(bus),
    .pc_advance(pc_advance), .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Model: decode queue of {pc, instr}, one outstanding memory read, and the previous cycle's view.
  logic [63:0] mq[$];
  bit          rsp_pending = 1'b0;
  bit          rsp_flushed = 1'b0;
  int          rsp_wait    = 0;
  logic [31:0] rsp_word    = 32'h0;
  logic [31:0] inflight_pc = 32'h0;
  logic [31:0] req_pc      = 32'h0;
  bit          adv_exp     = 1'b0;
  bit          fault_m     = 1'b0;
  bit          prev_req = 1'b0, prev_rdy = 1'b0, prev_fl = 1'b0, prev_idle = 1'b0;
  bit          prev_adv = 1'b0, prev_fault = 1'b0;
  logic [31:0] prev_pc   = 32'hFFFF_FFFF;
  logic [31:0] prev_addr = 32'h0;
  int          prev_size = 0;
  int          fix_lat   = -1;
  bit          use_fix   = 1'b0;
  logic [31:0] fix_data  = 32'h0;
  int          adv_cnt   = 0;
  bit          last_adv  = 1'b0;
  bit          obs_req   = 1'b0;
  bit          obs_hs    = 1'b0;
  logic [31:0] obs_addr  = 32'h0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive inputs at negedge, check outputs, predict the effect of the coming edge.
  task automatic tick(input bit rdy, input bit idr, input bit fl);
    bit deliver, hs, exp_req, blocked, this_idle;
    flush              = fl;
    bus.imem_req_ready = rdy;
    bus.id_ready       = idr;
    deliver            = rsp_pending && (rsp_wait == 0);
    bus.imem_rsp_valid = deliver;
    bus.imem_rsp_data  = deliver ? rsp_word : 32'h0;
    #1;
    blocked = ALIGN_CHK && (prev_fault || (prev_pc[1:0] != 2'b00));
    if (prev_req) exp_req = !(prev_rdy || prev_fl);
    else exp_req = prev_idle && !prev_fl && !prev_adv && (prev_pc != IDLE_PC) &&
                   (prev_size < DEPTH) && !blocked;
    chk("req_valid", bus.imem_req_valid, exp_req);
    if (exp_req && bus.imem_req_valid === 1'b1)
      chk("req_addr", bus.imem_req_addr, prev_req ? prev_addr : {prev_pc[31:2], 2'b00});
    if (bus.imem_req_valid === 1'b1 && !prev_req) req_pc = prev_pc;
    chk("if_valid", bus.if_valid, mq.size() != 0);
    if (mq.size() != 0) begin
      chk("if_pc", bus.if_pc, mq[0][63:32]);
      chk("if_instr", bus.if_instr, mq[0][31:0]);
    end
    chk("pc_advance", pc_advance, adv_exp && !fl);
    chk("fetch_fault", fetch_fault, fault_m);
    last_adv = (pc_advance === 1'b1);
    if (last_adv) adv_cnt++;
    hs        = (bus.imem_req_valid === 1'b1) && rdy;
    this_idle = (bus.imem_req_valid !== 1'b1) && !rsp_pending;
    obs_req   = (bus.imem_req_valid === 1'b1);
    obs_hs    = hs;
    obs_addr  = bus.imem_req_addr;
    prev_idle = this_idle;
    prev_req  = obs_req;
    prev_rdy  = rdy;
    prev_fl   = fl;
    prev_pc   = pc;
    prev_addr = bus.imem_req_addr;
    prev_size = mq.size();
    prev_adv  = adv_exp;
    prev_fault = fault_m;
    adv_exp   = deliver && !rsp_flushed && !fl;
    if (ALIGN_CHK) begin
      if (fl) fault_m = 1'b0;
      else if (this_idle && pc != IDLE_PC && pc[1:0] != 2'b00) fault_m = 1'b1;
    end
    if (fl) begin
      mq.delete();
      if (rsp_pending) rsp_flushed = 1'b1;
    end else begin
      if (mq.size() != 0 && idr) void'(mq.pop_front());
      if (deliver && !rsp_flushed) mq.push_back({inflight_pc, rsp_word});
    end
    if (deliver) rsp_pending = 1'b0;
    else if (rsp_pending && rsp_wait > 0) rsp_wait--;
    if (hs) begin
      rsp_pending = 1'b1;
      rsp_flushed = fl;
      inflight_pc = req_pc;
      rsp_word    = use_fix ? fix_data : $urandom();
      rsp_wait    = (fix_lat >= 0) ? fix_lat : $urandom_range(0, 2);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int adv0;
    rst = 1'b1; flush = 1'b0; pc = IDLE_PC;
    bus.imem_req_ready = 1'b0; bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data = 32'h0; bus.id_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_valid", bus.imem_req_valid, 1'b0);
    chk("rst_if_valid", bus.if_valid, 1'b0);
    chk("rst_pc_advance", pc_advance, 1'b0);
    chk("rst_fetch_fault", fetch_fault, 1'b0);
    rst = 1'b0;

    // Sentinel PC: nothing is ever fetched.
    repeat (10) tick(1'b1, 1'b1, 1'b0);

    // First fetch at pc 0 with a one-cycle memory.
    use_fix = 1'b1; fix_data = 32'h2008_0005; fix_lat = 0; pc = 32'h0; adv_cnt = 0;
    for (int i = 0; i < 20 && adv_cnt == 0; i++) tick(1'b1, 1'b0, 1'b0);
    chk("first_adv_cnt", adv_cnt, 1);
    chk("first_if_pc", bus.if_pc, 32'h0);
    chk("first_if_instr", bus.if_instr, 32'h2008_0005);
    use_fix = 1'b0;

    // PC steps 4, 8 with decode stalled: FIFO fills at DEPTH, third fetch waits for a pop.
    pc = 32'h4;
    for (int i = 0; i < 40 && adv_cnt < 2; i++) begin
      tick(1'b1, 1'b0, 1'b0);
      if (last_adv) pc = pc + 32'h4;
    end
    repeat (6) tick(1'b1, 1'b0, 1'b0);
    chk("full_adv_total", adv_cnt, 2);
    chk("full_no_req", obs_req, 1'b0);
    chk("full_if_valid", bus.if_valid, 1'b1);
    tick(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 10 && !obs_req; i++) tick(1'b0, 1'b0, 1'b0);
    chk("third_req_addr", obs_addr, 32'h8);

    // Flush while waiting: response dropped, refetch from the new pc.
    pc = IDLE_PC;
    repeat (8) tick(1'b1, 1'b1, 1'b0);
    pc = 32'h10; fix_lat = 1;
    for (int i = 0; i < 10 && !obs_hs; i++) tick(1'b1, 1'b0, 1'b0);
    chk("flush_hs_seen", obs_hs, 1'b1);
    pc = ALIGN_CHK ? 32'hFC : 32'hFF;
    adv0 = adv_cnt;
    tick(1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    chk("flush_no_adv", adv_cnt, adv0);
    chk("flush_if_valid", bus.if_valid, 1'b0);
    for (int i = 0; i < 10 && !obs_req; i++) tick(1'b0, 1'b0, 1'b0);
    chk("refetch_addr", obs_addr, 32'hFC);
    tick(1'b1, 1'b1, 1'b0);

    // Memory stalls for 5 cycles: request held steady.
    pc = IDLE_PC; fix_lat = -1;
    repeat (8) tick(1'b1, 1'b1, 1'b0);
    pc = 32'h40;
    for (int i = 0; i < 10 && !obs_req; i++) tick(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 1'b1, 1'b0);
      chk("hold_valid", obs_req, 1'b1);
      chk("hold_addr", obs_addr, 32'h40);
    end
    tick(1'b1, 1'b1, 1'b0);
    pc = IDLE_PC;
    repeat (6) tick(1'b1, 1'b1, 1'b0);

    // Misaligned pc traps when the check is built in; flush clears it.
    if (ALIGN_CHK) begin
      pc = 32'h6;
      repeat (4) tick(1'b1, 1'b1, 1'b0);
      chk("fault_set", fetch_fault, 1'b1);
      chk("fault_no_req", obs_req, 1'b0);
      pc = IDLE_PC;
      tick(1'b1, 1'b1, 1'b1);
      tick(1'b1, 1'b1, 1'b0);
      chk("fault_cleared", fetch_fault, 1'b0);
    end

    // Random traffic: stalls, pops, flushes and PC changes.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 99) < 25)
        pc = ($urandom_range(0, 99) < 8) ? IDLE_PC : {22'h0, 8'($urandom_range(0, 255)), 2'b00};
      tick($urandom_range(0, 99) < 70, $urandom_range(0, 1) == 1, $urandom_range(0, 99) < 4);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
